maze_move_engine: RTL and testbench

Parametrised, multi-agent successor to the single-agent Pac-Man move checker. Serves move requests for N_AGENTS maze actors (Pac-Man plus ghosts) in round-robin order against one shared external wall ROM. Adds per-agent heading memory with "keep going" fallback, optional tunnel wrap-around and a position-load port. Sits between the controller/ghost-AI logic and the sprite renderer, and owns every agent's position register.

---
 rtl/maze_pkg.sv | 75 +++++++
 rtl/maze_move_engine_rr_arbiter.sv | 40 ++++
 rtl/maze_move_engine.sv | 186 ++++++++++++++++++
 tb/tb_maze_move_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze move engine: direction/state encodings,
// direction decode and single-step position arithmetic with optional wrap.
package maze_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [2:0] {IDLE, SEL, RD_A, CHK_A, RD_B, CHK_B} state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_dec_t;

    typedef struct packed {
        logic [31:0] pos;
        logic        inb;
    } step_t;

    // {up,down,left,right}; anything other than exactly one bit set is not a direction
    function automatic dir_dec_t decode_dir(input logic [3:0] d);
        dir_dec_t r;
        r.valid = 1'b1;
        r.dir   = UP;
        case (d)
            4'b1000: r.dir = UP;
            4'b0100: r.dir = DOWN;
            4'b0010: r.dir = LEFT;
            4'b0001: r.dir = RIGHT;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Row and column move independently; an edge crossing either wraps or
    // reports out-of-bounds with the position left unchanged.
    function automatic step_t step_pos(input logic [31:0] pos, input dir_t d,
                                       input int unsigned cols, input int unsigned rows,
                                       input logic wrap);
        int unsigned row;
        int unsigned col;
        step_t       r;
        row   = pos / cols;
        col   = pos % cols;
        r.inb = 1'b1;
        case (d)
            UP: begin
                if (row == 0) begin
                    if (wrap) row = rows - 1;
                    else      r.inb = 1'b0;
                end else row = row - 1;
            end
            DOWN: begin
                if (row == rows - 1) begin
                    if (wrap) row = 0;
                    else      r.inb = 1'b0;
                end else row = row + 1;
            end
            LEFT: begin
                if (col == 0) begin
                    if (wrap) col = cols - 1;
                    else      r.inb = 1'b0;
                end else col = col - 1;
            end
            RIGHT: begin
                if (col == cols - 1) begin
                    if (wrap) col = 0;
                    else      r.inb = 1'b0;
                end else col = col + 1;
            end
        endcase
        r.pos = 32'(row * cols + col);
        return r;
    endfunction

endpackage

// File: rtl/maze_move_engine_rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last granted index;
// the pointer advances only when the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_id_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_id_o = ptr_q;
        any_o    = 1'b0;
        gnt_o    = '0;
        cand     = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(ptr_q) + off) % N);
            if (!any_o && req_i[cand]) begin
                any_o    = 1'b1;
                gnt_id_o = cand;
            end
        end
        if (any_o) gnt_o[gnt_id_o] = 1'b1;
    end

    // Pointer starts at the last agent so the first search begins at agent 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             ptr_q <= IW'(N - 1);
        else if (en_i && any_o)  ptr_q <= gnt_id_o;
    end

endmodule

// File: rtl/maze_move_engine.sv
// Multi-agent maze move engine: round-robin service of per-agent move requests
// against an external synchronous wall ROM, with heading fallback and position load.
module maze_move_engine
    import maze_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 32,
    parameter int N_AGENTS = 4,
    parameter int WRAP     = 1,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS),
    localparam int PW  = CW + RW,
    localparam int IDW = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_AGENTS-1:0]    step_i,
    input  logic [4*N_AGENTS-1:0]  dir_i,
    input  logic                   load_i,
    input  logic [IDW-1:0]         load_id_i,
    input  logic [PW-1:0]          load_pos_i,
    output logic [RW-1:0]          rom_addr_o,
    input  logic [COLS-1:0]        rom_data_i,
    output logic [PW*N_AGENTS-1:0] pos_o,
    output logic [N_AGENTS-1:0]    done_o,
    output logic [N_AGENTS-1:0]    moved_o,
    output logic                   busy_o
);

    state_t                state_q, state_d;
    logic [N_AGENTS-1:0]   pending_q, pending_d;
    logic [PW-1:0]         pos_q [N_AGENTS];
    dir_t                  heading_q [N_AGENTS];
    logic [N_AGENTS-1:0]   hvalid_q;
    logic [IDW-1:0]        gid_q;
    logic [PW-1:0]         cand_a_q, cand_b_q;
    logic                  a_valid_q, a_inb_q, b_inb_q, try_b_q, cancel_q;
    dir_t                  dir_a_q, dir_b_q;
    logic [RW-1:0]         rom_addr_q;
    logic [N_AGENTS-1:0]   done_q, moved_q;

    logic [3:0]            dir_vec [N_AGENTS];
    logic [COLS-1:0]       rom_rev;
    logic [N_AGENTS-1:0]   gnt;
    logic [IDW-1:0]        gnt_id;
    logic                  gnt_any;

    logic                  sel_en, go_b, finish, commit, take_b;
    logic                  a_open, b_open;
    logic                  load_ok, load_hit_sel, load_hit_cur;
    dir_dec_t              dec_a;
    step_t                 nxt_a, nxt_b;
    logic                  a_inb_sel, b_inb_sel, try_b_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_AGENTS; gi++) begin : g_agent
            assign dir_vec[gi]            = dir_i[4*gi +: 4];
            assign pos_o[gi*PW +: PW]     = pos_q[gi];
        end
        // ROM bit COLS-1-col holds column col; reverse once so col indexes directly
        for (gi = 0; gi < COLS; gi++) begin : g_rom_rev
            assign rom_rev[gi] = rom_data_i[COLS-1-gi];
        end
    endgenerate

    rr_arbiter #(
        .N  (N_AGENTS),
        .IW (IDW)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (pending_q),
        .en_i     (sel_en),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (gnt_any)
    );

    always_comb begin
        dec_a     = decode_dir(dir_vec[gnt_id]);
        nxt_a     = step_pos(32'(pos_q[gnt_id]), dec_a.dir, COLS, ROWS, WRAP != 0);
        nxt_b     = step_pos(32'(pos_q[gnt_id]), heading_q[gnt_id], COLS, ROWS, WRAP != 0);
        a_inb_sel = nxt_a.inb && (nxt_a.pos < 32'(COLS * ROWS));
        b_inb_sel = nxt_b.inb && (nxt_b.pos < 32'(COLS * ROWS));
        try_b_sel = hvalid_q[gnt_id] && !(dec_a.valid && heading_q[gnt_id] == dec_a.dir);
    end

    assign a_open       = a_valid_q && a_inb_q && !rom_rev[cand_a_q[CW-1:0]];
    assign b_open       = b_inb_q && !rom_rev[cand_b_q[CW-1:0]];
    assign load_ok      = load_i && (32'(load_id_i) < N_AGENTS);
    assign load_hit_sel = load_ok && (load_id_i == gnt_id);
    assign load_hit_cur = load_ok && (load_id_i == gid_q);
    assign pending_d    = (pending_q & ~(sel_en ? gnt : '0)) | step_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // IDLE holds while a done pulse is out so consecutive completions never abut
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any && done_q == '0) state_d = SEL;
            SEL:     state_d = RD_A;
            RD_A:    state_d = CHK_A;
            CHK_A:   state_d = (!a_open && try_b_q) ? RD_B : IDLE;
            RD_B:    state_d = CHK_B;
            CHK_B:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_en = (state_q == SEL);
        go_b   = (state_q == CHK_A) && !a_open && try_b_q;
        finish = ((state_q == CHK_A) && !go_b) || (state_q == CHK_B);
        take_b = (state_q == CHK_B);
        commit = ((state_q == CHK_A) && a_open) || ((state_q == CHK_B) && b_open);
        busy_o = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            hvalid_q   <= '0;
            gid_q      <= '0;
            cand_a_q   <= '0;
            cand_b_q   <= '0;
            a_valid_q  <= 1'b0;
            a_inb_q    <= 1'b0;
            b_inb_q    <= 1'b0;
            try_b_q    <= 1'b0;
            cancel_q   <= 1'b0;
            dir_a_q    <= UP;
            dir_b_q    <= UP;
            rom_addr_q <= '0;
            done_q     <= '0;
            moved_q    <= '0;
            for (int i = 0; i < N_AGENTS; i++) begin
                pos_q[i]     <= '0;
                heading_q[i] <= UP;
            end
        end else begin
            pending_q <= pending_d;
            done_q    <= '0;
            moved_q   <= '0;
            if (sel_en) begin
                gid_q      <= gnt_id;
                cand_a_q   <= nxt_a.pos[PW-1:0];
                cand_b_q   <= nxt_b.pos[PW-1:0];
                a_valid_q  <= dec_a.valid;
                a_inb_q    <= a_inb_sel;
                b_inb_q    <= b_inb_sel;
                try_b_q    <= try_b_sel;
                dir_a_q    <= dec_a.dir;
                dir_b_q    <= heading_q[gnt_id];
                rom_addr_q <= nxt_a.pos[PW-1:CW];
                cancel_q   <= load_hit_sel;
            end else begin
                cancel_q   <= cancel_q | load_hit_cur;
            end
            if (go_b) rom_addr_q <= cand_b_q[PW-1:CW];
            if (finish) begin
                done_q[gid_q] <= 1'b1;
                if (commit && !cancel_q && !load_hit_cur) begin
                    moved_q[gid_q]   <= 1'b1;
                    pos_q[gid_q]     <= take_b ? cand_b_q : cand_a_q;
                    heading_q[gid_q] <= take_b ? dir_b_q : dir_a_q;
                    hvalid_q[gid_q]  <= 1'b1;
                end
            end
            // A load always wins over a same-cycle commit to the same agent
            if (load_ok) begin
                pos_q[load_id_i]    <= load_pos_i;
                hvalid_q[load_id_i] <= 1'b0;
            end
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign done_o     = done_q;
    assign moved_o    = moved_q;

endmodule

// File: tb/tb_maze_move_engine.sv
// Scoreboard bench: two engines (wrap on / wrap off) share stimulus and a wall ROM;
// expected completions are queued at issue time and matched by per-engine monitors.
module tb_maze_move_engine;

    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int NA   = 4;
    localparam int PW   = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NA-1:0]  step;
    logic [4*NA-1:0] dir;
    logic           load;
    logic [1:0]     load_id;
    logic [PW-1:0]  load_pos;

    logic [4:0]     rom_addr1, rom_addr0;
    logic [31:0]    rom_data1, rom_data0;
    logic [PW*NA-1:0] pos1, pos0;
    logic [NA-1:0]  done1, done0, moved1, moved0;
    logic           busy1, busy0;

    logic [31:0]    mem [ROWS];
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;

    typedef struct {
        int id;
        int pos;
        int moved;
        int cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    maze_move_engine #(.COLS(COLS), .ROWS(ROWS), .N_AGENTS(NA), .WRAP(1)) dut_w1 (
        .clk_i(clk), .rst_ni(rst_n), .step_i(step), .dir_i(dir), .load_i(load),
        .load_id_i(load_id), .load_pos_i(load_pos), .rom_addr_o(rom_addr1),
        .rom_data_i(rom_data1), .pos_o(pos1), .done_o(done1), .moved_o(moved1),
        .busy_o(busy1)
    );

    maze_move_engine #(.COLS(COLS), .ROWS(ROWS), .N_AGENTS(NA), .WRAP(0)) dut_w0 (
        .clk_i(clk), .rst_ni(rst_n), .step_i(step), .dir_i(dir), .load_i(load),
        .load_id_i(load_id), .load_pos_i(load_pos), .rom_addr_o(rom_addr0),
        .rom_data_i(rom_data0), .pos_o(pos0), .done_o(done0), .moved_o(moved0),
        .busy_o(busy0)
    );

    always @(posedge clk) begin
        rom_data1 <= mem[rom_addr1];
        rom_data0 <= mem[rom_addr0];
        cyc       <= cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int w, input int id, input int pos, input int mv, input int c);
        exp_t e;
        e.id = id; e.pos = pos; e.moved = mv; e.cyc = c;
        if (w == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic mon(input int w, input logic [NA-1:0] d, input logic [NA-1:0] m,
                       input logic [PW*NA-1:0] p);
        exp_t e;
        if (d == '0) begin
            chk($sformatf("w%0d moved_without_done", w), m, 0);
        end else if ((w == 1 && q1.size() == 0) || (w == 0 && q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL w%0d unexpected_done: got done=%b expected none (cycle %0d)", w, d, cyc);
        end else begin
            if (w == 1) e = q1.pop_front();
            else        e = q0.pop_front();
            chk($sformatf("w%0d done_mask a%0d", w, e.id), d, 1 << e.id);
            chk($sformatf("w%0d done_cycle a%0d", w, e.id), cyc, e.cyc);
            chk($sformatf("w%0d pos a%0d", w, e.id), p[e.id*PW +: PW], e.pos);
            chk($sformatf("w%0d moved a%0d", w, e.id), m, e.moved << e.id);
            $display("done w%0d agent %0d pos %0d moved %0d cycle %0d", w, e.id,
                     p[e.id*PW +: PW], m[e.id], cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1, done1, moved1, pos1);
            mon(0, done0, moved0, pos0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " w1 pos"}, pos1, 0);
        chk({tag, " w0 pos"}, pos0, 0);
        chk({tag, " w1 done"}, done1, 0);
        chk({tag, " w1 moved"}, moved1, 0);
        chk({tag, " w1 busy"}, busy1, 0);
        chk({tag, " w1 rom_addr"}, rom_addr1, 0);
        chk({tag, " w0 busy"}, busy0, 0);
        chk({tag, " w0 rom_addr"}, rom_addr0, 0);
    endtask

    task automatic do_load(input int id, input int p);
        load = 1'b1; load_id = 2'(id); load_pos = PW'(p);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic issue(input logic [NA-1:0] m, input logic [4*NA-1:0] d, output int k);
        dir  = d;
        step = m;
        k    = cyc + 1;
        @(posedge clk); #1;
        step = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q1.size() != 0 || q0.size() != 0 || busy1 || busy0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got %0d/%0d outstanding after %0d cycles expected 0/0",
                     q1.size(), q0.size(), n);
            q1.delete();
            q0.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0; step = '0; dir = '0; load = 1'b0; load_id = '0; load_pos = '0;
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        mem[0][COLS-1-3] = 1'b1;
        mem[1][COLS-1-3] = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three agents stepped together, agent 0 re-stepped while in service
        do_load(0, 200);
        do_load(1, 300);
        do_load(2, 400);
        issue(4'b0111, 16'h0444, k);
        push(1, 0, 232, 1, k + 4);  push(0, 0, 232, 1, k + 4);
        push(1, 1, 332, 1, k + 9);  push(0, 1, 332, 1, k + 9);
        push(1, 2, 432, 1, k + 14); push(0, 2, 432, 1, k + 14);
        push(1, 0, 264, 1, k + 19); push(0, 0, 264, 1, k + 19);
        @(posedge clk); #1;
        @(posedge clk); #1;
        step = 4'b0001;
        @(posedge clk); #1;
        step = '0;
        wait_idle();

        // Open step right
        do_load(0, 33);
        issue(4'b0001, 16'h0001, k);
        push(1, 0, 34, 1, k + 4); push(0, 0, 34, 1, k + 4);
        wait_idle();

        // Up into open row 0, then right into a wall falls back to heading up
        issue(4'b0001, 16'h0008, k);
        push(1, 0, 2, 1, k + 4); push(0, 0, 2, 1, k + 4);
        wait_idle();
        issue(4'b0001, 16'h0001, k);
        push(1, 0, 994, 1, k + 6); push(0, 0, 2, 0, k + 6);
        wait_idle();

        // Reset asserted while in CHK_B of a heading-only request
        issue(4'b0001, 16'h0000, k);
        repeat (5) @(posedge clk);
        #1;
        chk("chk_b w1 busy", busy1, 1);
        chk("chk_b w1 rom_addr", rom_addr1, 30);
        chk("chk_b w0 rom_addr", rom_addr0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        chk("mid_reset w0 done", done0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset w1 busy", busy1, 0);
        chk("post_reset w1 pos", pos1, 0);
        wait_idle();

        // Left off column 0: wraps on one engine, blocked on the other
        do_load(0, 32);
        issue(4'b0001, 16'h0002, k);
        push(1, 0, 63, 1, k + 4); push(0, 0, 32, 0, k + 4);
        wait_idle();

        // Load of the agent in service during RD_A suppresses its commit
        issue(4'b0010, 16'h0040, k);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rd_a w1 busy", busy1, 1);
        load = 1'b1; load_id = 2'd1; load_pos = PW'(100);
        @(posedge clk); #1;
        load = 1'b0;
        push(1, 1, 100, 0, k + 4); push(0, 1, 100, 0, k + 4);
        wait_idle();

        chk("final w1 pos a0", pos1[0 +: PW], 63);
        chk("final w0 pos a0", pos0[0 +: PW], 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
